adc_spi_responder: RTL
======================

# adc_spi_responder

Responder side of the joystick ADC command/response stream, for use with an external SPI ADC (MCP3208-class, 8 channels, 12-bit) instead of the on-chip modular ADC. Accepts single-channel conversion commands on the same Avalon-ST command/response interface the movement logic already drives. Runs one SPI conversion per command and returns the 12-bit result with its channel tag. The block drops into the sys_clk domain in place of the qsys ADC core with no change to the command side.

## Interface
- CLK_DIV, 4: sys_clk cycles per SCLK half-period; legal values are 1 or more.
- sys_clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock sys_clk
- command_valid  in  1  command request
- command_channel  in  5  logical channel; 1..8 map to ADC CH0..CH7
- command_startofpacket, command_endofpacket  in  1  ignored
- command_ready  out  1  block can accept a command this cycle
- response_valid  out  1  one-cycle result pulse; there is no backpressure
- response_channel  out  5  channel of the accepted command
- response_data  out  12  conversion result
- response_startofpacket, response_endofpacket  out  1  equal to response_valid
- spi_cs_n  out  1  ADC chip select, active low
- spi_sclk  out  1  SPI clock, mode 0 (idles low)
- spi_mosi  out  1  command bits to ADC
- spi_miso  in  1  data bits from ADC; already synchronized externally

## Operation
- States: IDLE, CS_SETUP, SHIFT, RESP, CS_HOLD.
- All outputs are registered.
- A command is accepted on any edge where command_valid and command_ready are both 1. The channel is latched on that edge.
- command_ready is 1 only in IDLE.
- **Valid channel (1..8), on the accepting edge:**
  - Go to CS_SETUP.
  - spi_cs_n goes to 0.
  - spi_mosi takes the start bit (1).
- **CS_SETUP:** lasts CLK_DIV cycles with spi_sclk=0, then goes to SHIFT.
- **SHIFT:** 19 SCLK periods. Each period is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - On entry to each low phase, spi_mosi is updated to the next bit.
  - MOSI sequence by period: 1 = start, 2 = SGL (1), 3..5 = D2..D0 (ADC channel = command_channel-1, binary), 6..19 = 0.
  - spi_miso is sampled on the last sys_clk cycle of each high phase.
  - Samples from periods 8..19 are B11..B0, MSB first. Period 6 is the sample period; period 7 is the null bit; both are discarded.
- **After the last low phase, go to RESP:**
  - spi_cs_n=1.
  - response_valid=1 for exactly one cycle.
  - response_data = shifted word; response_channel = latched channel.
- **CS_HOLD:** lasts 2*CLK_DIV cycles with spi_cs_n=1, then goes to IDLE.
- **Invalid channel (0 or 9..31):**
  - No SPI activity.
  - Go straight to RESP with response_data=12'h000 and the channel echoed.
  - Then return directly to IDLE; CS_HOLD is skipped.
- response_data and response_channel hold their last values between pulses.
- command_valid held high is not a new request until the next ready cycle.
- Commands presented while not ready are not latched and not queued.

## Timing
- **Reset values:**
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0
  - response_valid=0, response_data=0, response_channel=0, sop=eop=0
  - command_ready=0 during reset, 1 in the first cycle after reset deasserts; state IDLE.
- **Reset mid-operation** (any state):
  - Abort on the reset edge; spi_cs_n goes to 1 immediately.
  - No response pulse is generated for the aborted command.
  - The partial shift word is discarded.
- **Valid channel, accepting edge k (D=CLK_DIV):**
  - response_valid is high in the cycle after edge k+39D.
  - command_ready returns after edge k+41D+1.
  - Command-to-command period is 41D+2 cycles.
- **Invalid channel, accepting edge k:**
  - response_valid is high after edge k+1.
  - command_ready returns after edge k+2.
- spi_sclk high time and low time are each exactly D cycles; there are exactly 19 rising edges per frame.
- spi_mosi changes only while spi_sclk=0 and spi_cs_n=0 (or on the entry to CS_SETUP).
- The response pulse never overlaps spi_cs_n=0.

## Test plan
- ADC model returns 0xABC on CH0; issue channel 1 (D=4).
  - Response pulse 156 cycles after accept, data 0xABC, channel 1.
  - 19 SCLK rising edges; MOSI bits 1,1,0,0,0.
- Channel 8, model returns 0x001.
  - MOSI D2..D0=111; data 0x001, channel 8.
- Channel 0, then channel 12.
  - Each gets a response 1 cycle after accept with data 0x000 and its channel echoed.
  - spi_cs_n stays 1 and spi_sclk stays 0 throughout.
- command_valid held high, channels alternating 1/2.
  - Accepts spaced 166 cycles apart; no lost or duplicated responses.
- Assert reset during SHIFT at period 10.
  - spi_cs_n=1 on the next edge; no response_valid.
  - command_ready=1 one cycle after reset releases.
  - The next conversion is correct.
- CLK_DIV=1: channel 3 with model 0x7FF.
  - Response after 39 cycles, data 0x7FF.
  - SCLK half-periods are 1 cycle.

Source files
------------

// File: rtl/adc_spi_responder_if.sv
// Command/response stream between the movement logic and the ADC responder.
// The master issues channel commands; the slave returns tagged 12-bit results.
interface adc_spi_responder_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;

    modport master (
        output command_valid, command_channel,
        output command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket
    );

    modport slave (
        input  command_valid, command_channel,
        input  command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Single-channel conversion responder driving an MCP3208-class SPI ADC.
// One SPI frame per command; result returned with its channel tag.
module adc_spi_responder #(
    parameter int CLK_DIV = 4
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    adc_spi_responder_if.slave   bus,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, RESP, CS_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  per_q, per_d;
    logic [4:0]  ch_q, ch_d;
    logic        bad_q, bad_d;
    logic [11:0] sh_q, sh_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        rdy_q, rdy_d;
    logic        vld_q, vld_d;
    logic [11:0] dat_q, dat_d;
    logic [4:0]  rch_q, rch_d;
    logic [2:0]  adc_ch;
    logic        next_bit;
    logic        ch_ok;
    logic        unused_sop_eop;

    assign unused_sop_eop = bus.command_startofpacket
                          ^ bus.command_endofpacket;
    assign adc_ch = ch_q[2:0] - 3'd1;
    assign ch_ok = (bus.command_channel != 5'd0)
                && (bus.command_channel <= 5'd8);

    // Bit presented during the period after per_q
    always_comb begin
        next_bit = 1'b0;
        case (per_q)
            5'd1:    next_bit = 1'b1;
            5'd2:    next_bit = adc_ch[2];
            5'd3:    next_bit = adc_ch[1];
            5'd4:    next_bit = adc_ch[0];
            default: next_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        ch_d    = ch_q;
        bad_d   = bad_q;
        sh_d    = sh_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rdy_d   = rdy_q;
        vld_d   = 1'b0;
        dat_d   = dat_q;
        rch_d   = rch_q;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (rdy_q && bus.command_valid) begin
                    rdy_d = 1'b0;
                    ch_d  = bus.command_channel;
                    sh_d  = 12'h000;
                    if (ch_ok) begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        mosi_d  = 1'b1;
                        cnt_d   = HALF;
                        bad_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                        cnt_d   = CW'(1);
                        bad_d   = 1'b1;
                    end
                end
            end
            CS_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    cnt_d   = HALF;
                    per_d   = 5'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sclk_q) begin
                    sclk_d = 1'b0;
                    cnt_d  = HALF;
                    mosi_d = next_bit;
                    if (per_q >= 5'd8)
                        sh_d = {sh_q[10:0], spi_miso};
                end else if (per_q == 5'd19) begin
                    state_d = RESP;
                    cs_n_d  = 1'b1;
                    vld_d   = 1'b1;
                    dat_d   = sh_q;
                    rch_d   = ch_q;
                    cnt_d   = '0;
                end else begin
                    sclk_d = 1'b1;
                    per_d  = per_q + 5'd1;
                    cnt_d  = HALF;
                end
            end
            RESP: begin
                // Rejected commands wait one cycle here before pulsing
                if (cnt_q != '0) begin
                    cnt_d = '0;
                    vld_d = 1'b1;
                    dat_d = 12'h000;
                    rch_d = ch_q;
                end else if (bad_q) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = CS_HOLD;
                    cnt_d   = HOLD;
                end
            end
            CS_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= 5'd0;
            ch_q    <= 5'd0;
            bad_q   <= 1'b0;
            sh_q    <= 12'h000;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            dat_q   <= 12'h000;
            rch_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            ch_q    <= ch_d;
            bad_q   <= bad_d;
            sh_q    <= sh_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            rch_q   <= rch_d;
        end
    end

    assign bus.command_ready          = rdy_q;
    assign bus.response_valid         = vld_q;
    assign bus.response_data          = dat_q;
    assign bus.response_channel       = rch_q;
    assign bus.response_startofpacket = vld_q;
    assign bus.response_endofpacket   = vld_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
endmodule
